// File: rtl/modinv_helper_pkg.sv
// Shared types and constants for the modular-invertor helper blocks.
package modinv_helper_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPass1,
    StDecide,
    StPass2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // One issue cycle per word plus one trailing consume cycle.
  function automatic int unsigned pass_cycles(input int unsigned n);
    return n + 1;
  endfunction

  function automatic int unsigned total_cycles(input int unsigned n);
    return 2 * pass_cycles(n) + 1;
  endfunction

endpackage

// File: rtl/modinv_sub32_borrow.sv
// 32-bit subtractor with borrow in/out: diff = a - b - bin.
module modinv_sub32_borrow (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] diff,
  output logic        bout
);

  logic [32:0] full;

  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    diff = full[31:0];
    bout = full[32];
  end

endmodule

// File: rtl/modinv_helper_double_mod.sv
// In-place modular doubling s := 2s mod q over word-serial buffers; both candidates
// go to u (2s) and v (2s-q), the final borrow picks the winner copied back into s.
module modinv_helper_double_mod
  import modinv_helper_pkg::*;
#(
  parameter int unsigned OPERAND_NUM_WORDS = 8,
  parameter int unsigned OPERAND_ADDR_BITS = 3,
  parameter int unsigned BUFFER_NUM_WORDS  = 9,
  parameter int unsigned BUFFER_ADDR_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  output logic                         rdy,
  output logic                         sel_sub,
  output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
  input  logic [31:0]                  s_din,
  output logic                         s_wren,
  output logic [31:0]                  s_dout,
  output logic [OPERAND_ADDR_BITS-1:0] q_addr,
  input  logic [31:0]                  q_din,
  output logic [BUFFER_ADDR_BITS-1:0]  u_addr,
  input  logic [31:0]                  u_din,
  output logic                         u_wren,
  output logic [31:0]                  u_dout,
  output logic [BUFFER_ADDR_BITS-1:0]  v_addr,
  input  logic [31:0]                  v_din,
  output logic                         v_wren,
  output logic [31:0]                  v_dout
);

  localparam int unsigned PassCycles = pass_cycles(BUFFER_NUM_WORDS);
  localparam int unsigned CntBits    = clog2(PassCycles);
  localparam int unsigned LastCnt    = PassCycles - 1;

  state_e             state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic               carry_q, borrow_q, sel_sub_q;

  logic [CntBits-1:0] word_idx;
  logic               issue, consume, last;
  logic [31:0]        dbl, q_word, diff;
  logic               bout;

  assign last     = (cnt_q == CntBits'(LastCnt));
  assign issue    = !last;
  assign consume  = (cnt_q != '0);
  assign word_idx = cnt_q - CntBits'(1);

  assign dbl    = {s_din[30:0], carry_q};
  // Words above the modulus width see q = 0.
  assign q_word = (32'(word_idx) < OPERAND_NUM_WORDS) ? q_din : 32'd0;

  modinv_sub32_borrow u_sub (
    .a    (dbl),
    .b    (q_word),
    .bin  (borrow_q),
    .diff (diff),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
      sel_sub_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle) begin
        carry_q  <= 1'b0;
        borrow_q <= 1'b0;
      end else if (state_q == StPass1 && consume) begin
        carry_q  <= s_din[31];
        borrow_q <= bout;
      end
      // No final borrow means 2s >= q, so the subtracted candidate wins.
      if (state_q == StDecide) sel_sub_q <= ~borrow_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ena) begin
          state_d = StPass1;
          cnt_d   = '0;
        end
      end
      StPass1: begin
        if (last) begin
          state_d = StDecide;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntBits'(1);
        end
      end
      StDecide: begin
        state_d = StPass2;
        cnt_d   = '0;
      end
      StPass2: begin
        if (last) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntBits'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_addr = '0;
    s_wren = 1'b0;
    s_dout = '0;
    q_addr = '0;
    u_addr = '0;
    u_wren = 1'b0;
    u_dout = '0;
    v_addr = '0;
    v_wren = 1'b0;
    v_dout = '0;
    if (state_q == StPass1) begin
      if (issue) begin
        s_addr = BUFFER_ADDR_BITS'(cnt_q);
        if (32'(cnt_q) < OPERAND_NUM_WORDS) q_addr = OPERAND_ADDR_BITS'(cnt_q);
      end
      if (consume) begin
        u_addr = BUFFER_ADDR_BITS'(word_idx);
        v_addr = BUFFER_ADDR_BITS'(word_idx);
        u_wren = 1'b1;
        v_wren = 1'b1;
        u_dout = dbl;
        v_dout = diff;
      end
    end else if (state_q == StPass2) begin
      if (issue) begin
        if (sel_sub_q) v_addr = BUFFER_ADDR_BITS'(cnt_q);
        else           u_addr = BUFFER_ADDR_BITS'(cnt_q);
      end
      if (consume) begin
        s_addr = BUFFER_ADDR_BITS'(word_idx);
        s_wren = 1'b1;
        s_dout = sel_sub_q ? v_din : u_din;
      end
    end
  end

  assign rdy     = (state_q == StIdle);
  assign sel_sub = sel_sub_q;

endmodule
